// File: rtl/mult_4b_pkg.sv
// Shared widths and types for the 4x4 array multiplier.
// Operand and full-product widths used by mult_4b and its cells.
package mult_4b_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef logic [OP_W-1:0]   op_t;
  typedef logic [PROD_W-1:0] prod_t;

endpackage

// File: rtl/mult_4b_cell.sv
// mult_cell: 1-bit multiply cell, full-add of (a&b)+sum_in+carry_in.
// Ports: a, b, sum_in, carry_in (in); sum_out, carry_out (out).
module mult_cell (
  input  logic a,
  input  logic b,
  input  logic sum_in,
  input  logic carry_in,
  output logic sum_out,
  output logic carry_out
);

  logic pp;

  assign pp        = a & b;
  assign sum_out   = pp ^ sum_in ^ carry_in;
  assign carry_out = (pp & sum_in)
                   | (pp & carry_in)
                   | (sum_in & carry_in);

endmodule

// File: rtl/mult_4b.sv
// mult_4b: 4x4 unsigned ripple-carry array multiplier, registered out.
// Ports: clk, rst (sync, high), x, y in; out = (x*y) mod 16.
// Macro MULT_4B_OVF_EN adds prod_hi = (x*y)[7:4] and ovf = |prod_hi.
module mult_4b
  import mult_4b_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] x,
  input  logic [OP_W-1:0] y,
  output logic [OP_W-1:0] out
`ifdef MULT_4B_OVF_EN
  ,
  output logic [OP_W-1:0] prod_hi,
  output logic            ovf
`endif
);

  // s/c: sum and carry outputs of cell (row i, column j).
  // Row i adds x*y[i] to the previous row's result shifted
  // right by one; the low bit of each row is a product bit.
  logic [OP_W-1:0] s [OP_W];
  logic [OP_W-1:0] c [OP_W];
  prod_t           prod;

  for (genvar i = 0; i < OP_W; i++) begin : g_row
    for (genvar j = 0; j < OP_W; j++) begin : g_col
      logic si;
      logic ci;

      if (i == 0) begin : g_si0
        assign si = 1'b0;
      end else if (j == OP_W-1) begin : g_sitop
        assign si = c[i-1][OP_W-1];
      end else begin : g_si
        assign si = s[i-1][j+1];
      end

      if (j == 0) begin : g_ci0
        assign ci = 1'b0;
      end else begin : g_ci
        assign ci = c[i][j-1];
      end

      mult_cell u_cell (
        .a         (x[j]),
        .b         (y[i]),
        .sum_in    (si),
        .carry_in  (ci),
        .sum_out   (s[i][j]),
        .carry_out (c[i][j])
      );
    end
  end

  for (genvar i = 0; i < OP_W-1; i++) begin : g_plo
    assign prod[i] = s[i][0];
  end

  assign prod[PROD_W-2:OP_W-1] = s[OP_W-1];
  assign prod[PROD_W-1]        = c[OP_W-1][OP_W-1];

  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= prod[OP_W-1:0];
  end

`ifdef MULT_4B_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_hi <= '0;
      ovf     <= 1'b0;
    end else begin
      prod_hi <= prod[PROD_W-1:OP_W];
      ovf     <= |prod[PROD_W-1:OP_W];
    end
  end
`else
  // High product bits have no consumer in this build.
  logic [OP_W-1:0] unused_hi;
  assign unused_hi = prod[PROD_W-1:OP_W];
`endif

endmodule

// File: tb/tb_mult_4b.sv
// Self-checking bench for mult_4b: reset, directed table,
// exhaustive 256-pair sweep, and reset mid-stream.
module tb_mult_4b;

  logic       clk;
  logic       rst;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] out;
`ifdef MULT_4B_OVF_EN
  logic [3:0] prod_hi;
  logic       ovf;
`endif

  int ncmp;
  int nfail;

  mult_4b dut (
    .clk (clk),
    .rst (rst),
    .x   (x),
    .y   (y),
    .out (out)
`ifdef MULT_4B_OVF_EN
    ,
    .prod_hi (prod_hi),
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] lo;
    logic [3:0] hi;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_hi(input string nm,
                        input logic [3:0] exp_hi);
`ifdef MULT_4B_OVF_EN
    chk({nm, "_hi"}, prod_hi, exp_hi);
    chk({nm, "_ovf"}, {3'b0, ovf}, {3'b0, |exp_hi});
`else
    if (exp_hi === 4'bxxxx) $display("unexpected X");
`endif
  endtask

  // Apply inputs at negedge, sample 1 time unit after posedge.
  task automatic step(input logic r,
                      input logic [3:0] a,
                      input logic [3:0] b);
    @(negedge clk);
    rst = r;
    x   = a;
    y   = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] p;
    ncmp  = 0;
    nfail = 0;
    rst   = 1'b1;
    x     = 4'd7;
    y     = 4'd3;

    tbl[0] = '{x: 4'd8,  y: 4'd0,  lo: 4'h0, hi: 4'h0};
    tbl[1] = '{x: 4'd8,  y: 4'd9,  lo: 4'h8, hi: 4'h4};
    tbl[2] = '{x: 4'd13, y: 4'd9,  lo: 4'h5, hi: 4'h7};
    tbl[3] = '{x: 4'd13, y: 4'd6,  lo: 4'he, hi: 4'h4};
    tbl[4] = '{x: 4'd15, y: 4'd15, lo: 4'h1, hi: 4'he};
    tbl[5] = '{x: 4'd11, y: 4'd1,  lo: 4'hb, hi: 4'h0};

    step(1'b1, 4'd7, 4'd3);
    chk("rst1", out, 4'h0);
    chk_hi("rst1", 4'h0);
    step(1'b1, 4'd15, 4'd15);
    chk("rst2", out, 4'h0);
    chk_hi("rst2", 4'h0);

    for (int i = 0; i < 6; i++) begin
      step(1'b0, tbl[i].x, tbl[i].y);
      chk($sformatf("vec%0d", i), out, tbl[i].lo);
      chk_hi($sformatf("vec%0d", i), tbl[i].hi);
    end

    for (int i = 0; i < 256; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      a = i[7:4];
      b = i[3:0];
      p = 8'(a) * 8'(b);
      step(1'b0, a, b);
      chk($sformatf("ex_%0d_%0d", a, b), out, p[3:0]);
      chk_hi($sformatf("ex_%0d_%0d", a, b), p[7:4]);
    end

    step(1'b0, 4'd8, 4'd9);
    chk("pre_rst", out, 4'h8);
    step(1'b1, 4'd13, 4'd9);
    chk("mid_rst", out, 4'h0);
    chk_hi("mid_rst", 4'h0);
    step(1'b0, 4'd13, 4'd9);
    chk("post_rst", out, 4'h5);
    chk_hi("post_rst", 4'h7);

    // out must hold between rising edges.
    @(negedge clk);
    x = 4'd3;
    y = 4'd3;
    #2;
    chk("hold", out, 4'h5);
    @(posedge clk);
    #1;
    chk("hold_load", out, 4'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
